// File: rtl/store_narrow_unit.sv
// Sub-word store path for a word-wide memory without byte enables.
// SB/SH stores read the word, merge the target lanes and write it back; SW writes directly.
module store_narrow_unit #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_trunc_loss,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RD    = 3'd2,
    S_WAIT  = 3'd3,
    S_WR    = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_trunc_loss;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [31:0]       r_mem_wdata;
  logic              w_err;
  logic              w_trunc;
  logic [31:0]       w_merged;

  // Access legality, truncation check and lane merge, all from the captured request.
  always_comb begin
    w_err    = 1'b0;
    w_trunc  = 1'b0;
    w_merged = i_mem_rdata;
    case (r_mode)
      2'b00: begin
        w_err   = 1'b0;
        w_trunc = (r_wdata[31:8] != {24{r_wdata[7]}});
        w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_err   = r_addr[0];
        w_trunc = (r_wdata[31:16] != {16{r_wdata[15]}});
        w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      2'b10: begin
        w_err   = (r_addr[1:0] != 2'b00);
        w_trunc = 1'b0;
      end
      default: begin
        w_err   = 1'b1;
        w_trunc = 1'b0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_CHECK;
        else         w_state_nxt = S_IDLE;
      end
      S_CHECK: begin
        if (w_err)                 w_state_nxt = S_FIN;
        else if (r_mode == 2'b10)  w_state_nxt = S_WR;
        else                       w_state_nxt = S_RD;
      end
      S_RD:    w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == LAST_CNT) w_state_nxt = S_WR;
        else                   w_state_nxt = S_WAIT;
      end
      S_WR:    w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request capture and registered outputs (decoded from the next state).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= 32'h0000_0000;
      r_cnt        <= 2'b00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_trunc_loss <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_wdata  <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && i_start) begin
        r_mode  <= i_mode;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt + 2'd1;
      else                   r_cnt <= 2'b00;

      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_FIN);
      r_err        <= (w_state_nxt == S_FIN) && w_err;
      r_trunc_loss <= (w_state_nxt == S_FIN) && !w_err && w_trunc;
      r_mem_read   <= (w_state_nxt == S_RD);
      r_mem_write  <= (w_state_nxt == S_WR);

      // Word address appears with the first memory strobe and holds until the pulse of done.
      if (r_state == S_CHECK && !w_err)  r_mem_addr <= {r_addr[ADDR_W-1:2], 2'b00};
      else if (w_state_nxt == S_IDLE)    r_mem_addr <= '0;
      else                               r_mem_addr <= r_mem_addr;

      if (r_state == S_CHECK && w_state_nxt == S_WR)     r_mem_wdata <= r_wdata;
      else if (r_state == S_WAIT && w_state_nxt == S_WR) r_mem_wdata <= w_merged;
      else if (w_state_nxt == S_IDLE)                    r_mem_wdata <= 32'h0000_0000;
      else                                               r_mem_wdata <= r_mem_wdata;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_trunc_loss = r_trunc_loss;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: two instances (MEM_LAT 1 and 3) share stimulus;
// expected memory strobes and done pulses are queued at start and matched as they appear.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_val;
  longint      cyc = 0;

  logic        busy_s  [2];
  logic        done_s  [2];
  logic        err_s   [2];
  logic        trunc_s [2];
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] maddr_s [2];
  logic [31:0] mwd_s   [2];
  logic [31:0] rdata_s [2];
  longint      rd_cyc  [2] = '{-100, -100};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          inst;
    int          kind;   // 0 read, 1 write, 2 done
    longint      cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        trunc;
  } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_narrow_unit #(.MEM_LAT(1), .ADDR_W(32)) u_dut_l1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_addr(addr),
    .i_wdata(wdata), .o_busy(busy_s[0]), .o_done(done_s[0]), .o_err(err_s[0]),
    .o_trunc_loss(trunc_s[0]), .o_mem_addr(maddr_s[0]), .o_mem_read(rd_s[0]),
    .o_mem_write(wr_s[0]), .o_mem_wdata(mwd_s[0]), .i_mem_rdata(rdata_s[0])
  );

  store_narrow_unit #(.MEM_LAT(3), .ADDR_W(32)) u_dut_l3 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_addr(addr),
    .i_wdata(wdata), .o_busy(busy_s[1]), .o_done(done_s[1]), .o_err(err_s[1]),
    .o_trunc_loss(trunc_s[1]), .o_mem_addr(maddr_s[1]), .o_mem_read(rd_s[1]),
    .o_mem_write(wr_s[1]), .o_mem_wdata(mwd_s[1]), .i_mem_rdata(rdata_s[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: read data is valid only in the cycle MEM_LAT after the read strobe.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++)
      rdata_s[k] = (cyc == rd_cyc[k] + lat_of(k)) ? mem_val : 32'hBAD0_BAD0;
  end

  task automatic match_ev(input int k, input int kind);
    int    idx;
    string nm;
    idx = -1;
    nm  = (kind == 0) ? "rd" : ((kind == 1) ? "wr" : "done");
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].inst == k && sb[i].kind == kind) idx = i;
    chk($sformatf("%s_expected L%0d", nm, lat_of(k)), 64'(idx >= 0), 64'd1);
    if (idx >= 0) begin
      chk($sformatf("%s_cycle L%0d", nm, lat_of(k)), 64'(cyc), 64'(sb[idx].cyc));
      if (kind != 2)
        chk($sformatf("%s_addr L%0d", nm, lat_of(k)), 64'(maddr_s[k]), 64'(sb[idx].addr));
      if (kind == 1)
        chk($sformatf("wr_data L%0d", lat_of(k)), 64'(mwd_s[k]), 64'(sb[idx].data));
      if (kind == 2) begin
        chk($sformatf("done_err L%0d", lat_of(k)), 64'(err_s[k]), 64'(sb[idx].err));
        chk($sformatf("done_trunc L%0d", lat_of(k)), 64'(trunc_s[k]), 64'(sb[idx].trunc));
        chk($sformatf("done_busy L%0d", lat_of(k)), 64'(busy_s[k]), 64'd1);
      end
      sb.delete(idx);
    end
  endtask

  // Output monitor: sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_wr_excl L%0d", lat_of(k)), 64'(rd_s[k] & wr_s[k]), 64'd0);
      if (rd_s[k]) begin
        rd_cyc[k] = cyc;
        match_ev(k, 0);
      end
      if (wr_s[k]) match_ev(k, 1);
      if (done_s[k]) match_ev(k, 2);
      else begin
        chk($sformatf("err_idle L%0d", lat_of(k)), 64'(err_s[k]), 64'd0);
        chk($sformatf("trunc_idle L%0d", lat_of(k)), 64'(trunc_s[k]), 64'd0);
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_busy L%0d", tag, lat_of(k)), 64'(busy_s[k]), 64'd0);
      chk($sformatf("%s_done L%0d", tag, lat_of(k)), 64'(done_s[k]), 64'd0);
      chk($sformatf("%s_rd L%0d", tag, lat_of(k)), 64'(rd_s[k]), 64'd0);
      chk($sformatf("%s_wr L%0d", tag, lat_of(k)), 64'(wr_s[k]), 64'd0);
      chk($sformatf("%s_maddr L%0d", tag, lat_of(k)), 64'(maddr_s[k]), 64'd0);
      chk($sformatf("%s_mwdata L%0d", tag, lat_of(k)), 64'(mwd_s[k]), 64'd0);
      chk($sformatf("%s_err L%0d", tag, lat_of(k)), 64'(err_s[k]), 64'd0);
      chk($sformatf("%s_trunc L%0d", tag, lat_of(k)), 64'(trunc_s[k]), 64'd0);
    end
  endtask

  // One store: queue expectations, pulse start, optional second start / reset, then drain.
  task automatic do_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rv, input int extra, input int rst_at);
    longint      t;
    logic        e, tr;
    logic [31:0] mask, mg, wa;
    ev_t         ev;
    @(posedge clk); #1;
    t = cyc;
    mode = m; addr = a; wdata = wd; mem_val = rv; start = 1'b1;
    e  = (m == 2'b11) || (m == 2'b01 && a[0]) || (m == 2'b10 && a[1:0] != 2'b00);
    wa = a & 32'hFFFF_FFFC;
    if (m == 2'b00) begin
      mask = 32'h0000_00FF << (8 * a[1:0]);
      mg   = (rv & ~mask) | ((wd & 32'h0000_00FF) << (8 * a[1:0]));
      tr   = (wd != {{24{wd[7]}}, wd[7:0]});
    end else begin
      mask = 32'h0000_FFFF << (16 * a[1]);
      mg   = (rv & ~mask) | ((wd & 32'h0000_FFFF) << (16 * a[1]));
      tr   = (wd != {{16{wd[15]}}, wd[15:0]});
    end
    for (int k = 0; k < 2; k++) begin
      ev.inst = k; ev.addr = wa; ev.data = 32'h0; ev.err = 1'b0; ev.trunc = 1'b0;
      if (e) begin
        ev.kind = 2; ev.cyc = t + 2; ev.err = 1'b1; sb.push_back(ev);
      end else if (m == 2'b10) begin
        ev.kind = 1; ev.cyc = t + 2; ev.data = wd; sb.push_back(ev);
        ev.kind = 2; ev.cyc = t + 3; ev.data = 32'h0; sb.push_back(ev);
      end else begin
        ev.kind = 0; ev.cyc = t + 2; sb.push_back(ev);
        if (rst_at == 0) begin
          ev.kind = 1; ev.cyc = t + 3 + lat_of(k); ev.data = mg; sb.push_back(ev);
          ev.kind = 2; ev.cyc = t + 4 + lat_of(k); ev.data = 32'h0; ev.trunc = tr;
          sb.push_back(ev);
        end
      end
    end
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        chk("busy_after_start L1", 64'(busy_s[0]), 64'd1);
        chk("busy_after_start L3", 64'(busy_s[1]), 64'd1);
      end
      if (extra != 0 && c == extra) begin
        start = 1'b1; mode = 2'b10; addr = 32'h0000_0040; wdata = 32'h5555_5555;
      end else if (extra != 0 && c == extra + 1) begin
        start = 1'b0;
      end
      if (rst_at != 0 && c == rst_at) reset = 1'b1;
      if (rst_at != 0 && c == rst_at + 1) begin
        check_zero("abort");
        reset = 1'b0;
      end
    end
    chk("busy_end L1", 64'(busy_s[0]), 64'd0);
    chk("busy_end L3", 64'(busy_s[1]), 64'd0);
    chk("sb_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; addr = 32'h0; wdata = 32'h0; mem_val = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    do_op(2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0);  // SW
    do_op(2'b00, 32'h0000_0006, 32'h0000_00AB, 32'h1122_3344, 0, 0);  // SB lane 2
    do_op(2'b01, 32'h0000_0002, 32'h1234_8000, 32'hFFFF_FFFF, 0, 0);  // SH, lossy
    do_op(2'b01, 32'h0000_0002, 32'hFFFF_8000, 32'hFFFF_FFFF, 0, 0);  // SH, lossless
    do_op(2'b01, 32'h0000_0000, 32'h0000_7FFF, 32'hA5A5_A5A5, 0, 0);  // SH lower half
    do_op(2'b00, 32'h0000_0001, 32'h0000_007F, 32'hAABB_CCDD, 0, 0);  // SB lane 1
    do_op(2'b00, 32'h0000_0003, 32'h0000_0180, 32'h0102_0304, 0, 0);  // SB lane 3, lossy
    do_op(2'b01, 32'h0000_0003, 32'h0000_1234, 32'h0, 0, 0);          // SH misaligned
    do_op(2'b10, 32'h0000_0002, 32'h0000_1234, 32'h0, 0, 0);          // SW misaligned
    do_op(2'b11, 32'h0000_0000, 32'h0000_1234, 32'h0, 0, 0);          // illegal mode
    do_op(2'b00, 32'h0000_0004, 32'hFFFF_FF80, 32'h9988_7766, 2, 0);  // start while busy
    do_op(2'b10, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 3, 0);          // start during done
    do_op(2'b00, 32'h0000_0008, 32'h0000_0011, 32'hCAFE_BABE, 0, 3);  // reset in WAIT
    do_op(2'b01, 32'h0000_000E, 32'h0000_4321, 32'h0F0F_0F0F, 0, 0);  // recovery after abort

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
